ysyx_22041461_lsu: RTL and testbench
====================================

Name: ysyx_22041461_lsu

Overview:
- Load/store unit between the execute stage and ysyx_22041461_DCACHE.
- Accepts one memory operation at a time and checks alignment.
- Drives the DCACHE request (addr/wdata/mask/wen), holding DCACHE_valid high until DCACHE_valid_out answers.
- Extracts and sign/zero-extends load data, then returns a one-cycle writeback result.
- A watchdog aborts requests that never complete.

Parameters:
- TIMEOUT, 256, max cycles in REQ before abort (≥2); counter width = clog2(TIMEOUT).

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  reset; asynchronous, active-high
- lsu_valid  in  1  upstream request valid
- lsu_ready  out  1  high only in IDLE; request accepted when lsu_valid & lsu_ready
- lsu_wen  in  1  1 = store, 0 = load
- lsu_op  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU (stores use bits[1:0] only)
- lsu_addr  in  64  byte address
- lsu_wdata  in  64  store data, low-aligned
- lsu_rd  in  5  destination register tag, returned unchanged
- DCACHE_valid  out  1  cache request valid
- DCACHE_addr  out  64  latched lsu_addr
- DCACHE_wdata  out  64  latched lsu_wdata
- DCACHE_mask  out  8  0x01 / 0x03 / 0x0F / 0xFF for B/H/W/D
- DCACHE_wen  out  1  latched lsu_wen
- DCACHE_valid_out  in  1  cache completion
- DCACHE_rdata  in  64  cache read data, 8-byte-aligned doubleword
- wb_valid  out  1  one-cycle result pulse
- wb_data  out  64  extended load data; 0 for stores, errors and when wb_valid = 0
- wb_rd  out  5  latched lsu_rd
- wb_misalign  out  1  qualifies wb_valid: access was misaligned
- wb_timeout  out  1  qualifies wb_valid: watchdog expired

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - lsu_ready = 1.
  - All other outputs 0, including DCACHE_valid, wb_valid, DCACHE_mask and all data buses.
  - Watchdog counter = 0.
  - A request in flight is dropped silently and no wb pulse is generated. The DCACHE sees DCACHE_valid fall in the same cycle.
- Misalignment:
  - H requires addr[0] = 0; W requires addr[1:0] = 0; D requires addr[2:0] = 0; B is always aligned.
  - Misaligned accesses never reach the cache.
- FSM, states IDLE / REQ / RESP:
  - IDLE: lsu_ready = 1.
    - On accept, latch addr, wdata, op, wen and rd.
    - Aligned: go to REQ, with DCACHE_valid = 1 from the next cycle.
    - Misaligned: go to RESP with misalign flag set.
  - REQ: DCACHE_valid = 1, with DCACHE_* outputs stable for the whole state.
    - When DCACHE_valid_out = 1 is sampled at edge M, capture DCACHE_rdata from that edge and go to RESP.
    - DCACHE_valid is 0 from cycle M+1. This prevents the cache's toggling valid_out from signalling twice.
    - Otherwise increment the watchdog. If the watchdog equals TIMEOUT-1 and valid_out = 0, go to RESP with the timeout flag set.
  - RESP: exactly one cycle.
    - wb_valid = 1, lsu_ready = 0.
    - Next state is IDLE; clear the flags and the watchdog.
- Load extraction:
  - shifted = DCACHE_rdata >> (8 * addr[2:0]).
  - B / H / W: sign-extend the low 8 / 16 / 32 bits.
  - BU / HU / WU: zero-extend.
  - D: all 64 bits.
  - op 111 is treated as D.
- Stores: wb_valid still pulses with wb_data = 0 to signal completion.
- Latency:
  - Accept edge N; DCACHE_valid high in cycles N+1 .. M; wb_valid in M+1; next accept possible at edge M+2.
  - Cache answering on the first REQ cycle: request-to-wb = 2 cycles.
  - Misaligned: wb_valid in N+1.
- wb_misalign and wb_timeout are never both 1.
- lsu_valid is ignored outside IDLE; upstream must hold its request until lsu_ready is high.

Test Plan:
- LB, addr 0x8000_0003, cache returns 0x0000_0000_8000_0000 → wb_data 0xFFFF_FFFF_FFFF_FF80, wb_rd echoed, DCACHE_mask 0x01.
- LHU, addr 0x8000_0006, rdata 0xBEEF_0000_0000_0000 → wb_data 0x0000_0000_0000_BEEF, no misalign.
- SW, addr 0x8000_0010, wdata 0x1234_5678:
  - DCACHE_wen = 1, mask 0x0F, wdata passed through.
  - valid_out asserted on the 1st REQ cycle → DCACHE_valid high exactly 1 cycle, wb_valid 1 cycle later, wb_data 0.
- LW, addr 0x8000_0002 → wb_valid + wb_misalign in the cycle after accept; DCACHE_valid never asserts.
- TIMEOUT = 8, LD with valid_out held 0 → DCACHE_valid high 8 cycles, then wb_valid + wb_timeout, wb_data 0, lsu_ready back 1 the cycle after.
- Assert rst during REQ → DCACHE_valid and lsu_ready respond immediately (0 and 1); no wb_valid after release; a new request completes normally.

Source files
------------

// File: rtl/ysyx_22041461_lsu.sv
// Load/store unit: takes one memory operation at a time, checks alignment, drives
// the DCACHE handshake and returns a single-cycle writeback result.
module ysyx_22041461_lsu #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        lsu_wen,
    input  logic [2:0]  lsu_op,
    input  logic [63:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    input  logic [4:0]  lsu_rd,
    output logic        DCACHE_valid,
    output logic [63:0] DCACHE_addr,
    output logic [63:0] DCACHE_wdata,
    output logic [7:0]  DCACHE_mask,
    output logic        DCACHE_wen,
    input  logic        DCACHE_valid_out,
    input  logic [63:0] DCACHE_rdata,
    output logic        wb_valid,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_misalign,
    output logic        wb_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_nxt;
    logic [63:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  op_q;
    logic [7:0]  mask_q;
    logic        wen_q, mis_q, to_q;
    logic [4:0]  rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic        accept, misaligned;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'b01:   return a[0];
            2'b10:   return |a[1:0];
            2'b11:   return |a[2:0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Shift the selected bytes down, then sign- or zero-extend by funct3.
    function automatic logic [63:0] extract(input logic [63:0] rdata, input logic [2:0] a,
                                            input logic [2:0] op);
        logic        [63:0] sh;
        logic signed [63:0] sx;
        sh = rdata >> {a, 3'b000};
        case (op)
            3'b000:  sx = 64'(signed'(sh[7:0]));
            3'b001:  sx = 64'(signed'(sh[15:0]));
            3'b010:  sx = 64'(signed'(sh[31:0]));
            3'b100:  sx = {56'd0, sh[7:0]};
            3'b101:  sx = {48'd0, sh[15:0]};
            3'b110:  sx = {32'd0, sh[31:0]};
            default: sx = sh;
        endcase
        return sx;
    endfunction

    assign accept     = (state == IDLE) && lsu_valid;
    assign misaligned = is_misaligned(lsu_op[1:0], lsu_addr[2:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = misaligned ? RESP : REQ;
            REQ:  if (DCACHE_valid_out || (cnt_q == CNT_W'(TIMEOUT - 1))) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            mask_q  <= '0;
            wen_q   <= 1'b0;
            rd_q    <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    addr_q  <= lsu_addr;
                    wdata_q <= lsu_wdata;
                    op_q    <= lsu_op;
                    wen_q   <= lsu_wen;
                    rd_q    <= lsu_rd;
                    mis_q   <= misaligned;
                    mask_q  <= misaligned ? 8'h00 : size_mask(lsu_op[1:0]);
                    rdata_q <= '0;
                end
                REQ: begin
                    if (DCACHE_valid_out) begin
                        rdata_q <= DCACHE_rdata;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        to_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    mis_q <= 1'b0;
                    to_q  <= 1'b0;
                    cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign lsu_ready    = (state == IDLE);
    assign DCACHE_valid = (state == REQ);
    assign DCACHE_addr  = addr_q;
    assign DCACHE_wdata = wdata_q;
    assign DCACHE_mask  = mask_q;
    assign DCACHE_wen   = wen_q;
    assign wb_valid     = (state == RESP);
    assign wb_rd        = rd_q;
    assign wb_misalign  = wb_valid && mis_q;
    assign wb_timeout   = wb_valid && to_q;
    // Only a successful load returns data; stores and errors report zero.
    assign wb_data      = (wb_valid && !wen_q && !mis_q && !to_q) ?
                          extract(rdata_q, addr_q[2:0], op_q) : 64'd0;
endmodule

// File: tb/tb_ysyx_22041461_lsu.sv
// Directed table-driven bench for the LSU, with a reset-during-request sequence.
module tb_ysyx_22041461_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_ready, lsu_wen;
    logic [2:0]  lsu_op;
    logic [63:0] lsu_addr, lsu_wdata;
    logic [4:0]  lsu_rd;
    logic        DCACHE_valid, DCACHE_wen, DCACHE_valid_out;
    logic [63:0] DCACHE_addr, DCACHE_wdata, DCACHE_rdata;
    logic [7:0]  DCACHE_mask;
    logic        wb_valid, wb_misalign, wb_timeout;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;

    int total = 0;
    int bad   = 0;

    ysyx_22041461_lsu #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
        .lsu_op(lsu_op), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rd(lsu_rd),
        .DCACHE_valid(DCACHE_valid), .DCACHE_addr(DCACHE_addr), .DCACHE_wdata(DCACHE_wdata),
        .DCACHE_mask(DCACHE_mask), .DCACHE_wen(DCACHE_wen),
        .DCACHE_valid_out(DCACHE_valid_out), .DCACHE_rdata(DCACHE_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_misalign(wb_misalign), .wb_timeout(wb_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] rdata;
        int          lat;    // REQ cycles before the cache answers; -1 = never
        logic [7:0]  mask;
        logic [63:0] exp_data;
        logic        mis;
        logic        to;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int high;
        int exp_high;
        @(posedge clk); #1;
        chk({tag, "_ready_idle"}, 64'(lsu_ready), 64'd1);
        lsu_valid = 1'b1;
        lsu_wen   = v.wen;
        lsu_op    = v.op;
        lsu_addr  = v.addr;
        lsu_wdata = v.wdata;
        lsu_rd    = v.rd;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        high = 0;
        while (DCACHE_valid && high < 20) begin
            chk({tag, "_mask"}, 64'(DCACHE_mask), 64'(v.mask));
            chk({tag, "_addr"}, DCACHE_addr, v.addr);
            chk({tag, "_wen"}, 64'(DCACHE_wen), 64'(v.wen));
            chk({tag, "_wdata"}, DCACHE_wdata, v.wdata);
            if (high == v.lat) begin
                DCACHE_valid_out = 1'b1;
                DCACHE_rdata     = v.rdata;
            end
            @(posedge clk); #1;
            DCACHE_valid_out = 1'b0;
            DCACHE_rdata     = 64'd0;
            high++;
        end
        exp_high = v.mis ? 0 : (v.to ? 8 : v.lat + 1);
        chk({tag, "_req_cycles"}, 64'(high), 64'(exp_high));
        chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
        chk({tag, "_wb_data"}, wb_data, v.exp_data);
        chk({tag, "_wb_rd"}, 64'(wb_rd), 64'(v.rd));
        chk({tag, "_wb_misalign"}, 64'(wb_misalign), 64'(v.mis));
        chk({tag, "_wb_timeout"}, 64'(wb_timeout), 64'(v.to));
        chk({tag, "_ready_resp"}, 64'(lsu_ready), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_wb_pulse_end"}, 64'(wb_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(lsu_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 64'h8000_0003, 64'h0, 5'd1, 64'h0000_0000_8000_0000, 1, 8'h01, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'b101, 64'h8000_0006, 64'h0, 5'd2, 64'hBEEF_0000_0000_0000, 2, 8'h03, 64'h0000_0000_0000_BEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 3'b010, 64'h8000_0010, 64'h1234_5678, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 8'h0F, 64'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b010, 64'h8000_0002, 64'h0, 5'd4, 64'h0, -1, 8'h00, 64'h0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 3'b011, 64'h8000_0008, 64'h0, 5'd5, 64'h0, -1, 8'hFF, 64'h0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 3'b010, 64'h8000_0004, 64'h0, 5'd6, 64'h8765_4321_0000_0000, 1, 8'h0F, 64'hFFFF_FFFF_8765_4321, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'b110, 64'h8000_0004, 64'h0, 5'd7, 64'h8765_4321_0000_0000, 0, 8'h0F, 64'h0000_0000_8765_4321, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'b100, 64'h8000_0007, 64'h0, 5'd8, 64'hF000_0000_0000_0000, 0, 8'h01, 64'h0000_0000_0000_00F0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 3'b001, 64'h8000_0002, 64'h0, 5'd9, 64'h0000_0000_8001_0000, 1, 8'h03, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'b011, 64'h8000_0008, 64'h0, 5'd10, 64'h0123_4567_89AB_CDEF, 3, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 3'b011, 64'h8000_0004, 64'hAAAA_BBBB_CCCC_DDDD, 5'd11, 64'h0, -1, 8'h00, 64'h0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 3'b000, 64'h8000_0001, 64'h0000_0000_0000_00AB, 5'd12, 64'h0, 1, 8'h01, 64'h0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 3'b111, 64'h8000_0000, 64'h0, 5'd13, 64'hDEAD_BEEF_CAFE_BABE, 0, 8'hFF, 64'hDEAD_BEEF_CAFE_BABE, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 3'b001, 64'h8000_0001, 64'h0, 5'd14, 64'h0, -1, 8'h00, 64'h0, 1'b1, 1'b0};

        rst = 1'b1;
        lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_op = 3'd0;
        lsu_addr = 64'd0; lsu_wdata = 64'd0; lsu_rd = 5'd0;
        DCACHE_valid_out = 1'b0; DCACHE_rdata = 64'd0;
        #1;
        chk("reset_ready", 64'(lsu_ready), 64'd1);
        chk("reset_dvalid", 64'(DCACHE_valid), 64'd0);
        chk("reset_wb_valid", 64'(wb_valid), 64'd0);
        chk("reset_mask", 64'(DCACHE_mask), 64'd0);
        chk("reset_addr", DCACHE_addr, 64'd0);
        chk("reset_wb_data", wb_data, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while a request is outstanding at the cache.
        @(posedge clk); #1;
        lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_op = 3'b011;
        lsu_addr = 64'h8000_0100; lsu_rd = 5'd9;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        chk("rst_pre_dvalid", 64'(DCACHE_valid), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_dvalid_drop", 64'(DCACHE_valid), 64'd0);
        chk("rst_ready_rise", 64'(lsu_ready), 64'd1);
        chk("rst_mask_clear", 64'(DCACHE_mask), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_no_wb", 64'(wb_valid), 64'd0);
            chk("rst_no_dvalid", 64'(DCACHE_valid), 64'd0);
        end
        run_vec(vecs[9], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
